deserializer_1to64_serdes: RTL and testbench
============================================

DESERIALIZER_1TO64_SERDES -- requirements
Module: deserializer_1to64_serdes

Interface
REQ-001 Parameter: WIDTH, 64, word width in bits; all counts below are stated for WIDTH=64.
REQ-002 Port: clk_serial  input  1  bit clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: serial_in  input  1  serial data bit, MSB of each word first.
REQ-005 Port: bit_valid  input  1  serial_in carries a valid bit this cycle.
REQ-006 Port: sof  input  1  start of frame; qualified by bit_valid; marks bit 63 (MSB) of a word.
REQ-007 Port: data_out  output  64  assembled word.
REQ-008 Port: valid_out  output  1  data_out holds an unconsumed word.
REQ-009 Port: ready_in  input  1  consumer accepts data_out this cycle.
REQ-010 Port: busy  output  1  a word is partially received (state SHIFT).
REQ-011 Port: overflow  output  1  one-cycle pulse: completed word dropped.
REQ-012 Port: frame_err  output  1  one-cycle pulse: sof arrived mid-word.

Function
REQ-013 The block SHALL implement two states, IDLE and SHIFT, plus a 6-bit bit counter and a 64-bit shift register.
REQ-014 In IDLE, bit_valid without sof SHALL be ignored; sof without bit_valid SHALL be ignored in every state.
REQ-015 In IDLE, sof&bit_valid SHALL load serial_in as the first bit, set count=1 and enter SHIFT.
REQ-016 In SHIFT, each bit_valid cycle SHALL shift left, inserting serial_in at LSB, and increment count; cycles with bit_valid=0 SHALL hold all state.
REQ-017 The bit sampled at count==63 SHALL complete the word {shift[62:0],serial_in}; the state SHALL return to IDLE on that edge.
REQ-018 The completed word SHALL appear on data_out with valid_out=1 in the cycle immediately after the 64th bit is sampled (latency 1 cycle).
REQ-019 A sof&bit_valid in the cycle following completion SHALL start a new word; no gap cycle is required between words.
REQ-020 sof&bit_valid while in SHIFT SHALL pulse frame_err for one cycle, discard the partial word, and restart with that bit as bit 63 (count=1, stay in SHIFT).
REQ-021 valid_out SHALL remain high and data_out stable until a cycle with ready_in=1; the word is consumed on that edge.
REQ-022 Completion with valid_out=0, or with valid_out=1 and ready_in=1 in the same cycle, SHALL load the new word; valid_out stays/goes 1.
REQ-023 Completion with valid_out=1 and ready_in=0 SHALL drop the new word, keep data_out unchanged, and pulse overflow for one cycle.
REQ-024 busy SHALL equal (state==SHIFT); overflow and frame_err SHALL be registered, high for exactly one cycle per event.
REQ-025 Completion in the same cycle as frame_err is impossible by construction (sof restarts the word); no precedence is required between them.

Reset
REQ-026 With rst=1 on a rising edge: state=IDLE, count=0, shift register=0, data_out=0, valid_out=0, busy=0, overflow=0, frame_err=0.
REQ-027 rst SHALL dominate every other input in the same cycle; a partial word or unconsumed output word SHALL be discarded.
REQ-028 After rst deasserts, data bits SHALL be ignored until the next sof&bit_valid.

Verification
REQ-029 Reset 2 cycles, then sof + 64 continuous bits of 64'hAAAABBBB_12345678 MSB first, ready_in=1 -> valid_out high exactly one cycle, one cycle after bit 64, data_out=64'hAAAABBBB_12345678, busy high for bits 1-63.
REQ-030 Two words 64'hAAAABBBB_00000001 and 64'hAAAABBBB_FFFFFFFE back-to-back (sof on bit 65), ready_in=1 -> two valid_out pulses 64 cycles apart with correct data, no frame_err/overflow.
REQ-031 bit_valid asserted every other cycle for word 64'h0123456789ABCDEF -> completion after 128 cycles, data_out=64'h0123456789ABCDEF.
REQ-032 sof reasserted at bit 20 of a word, then 64 bits of 64'hDEADBEEF_CAFEF00D -> frame_err pulses once, single valid_out with 64'hDEADBEEF_CAFEF00D.
REQ-033 ready_in=0, two complete words W1 then W2 -> overflow pulses once at W2 completion, data_out=W1 held; ready_in=1 -> valid_out drops next cycle.
REQ-034 rst asserted at bit 30, then 40 bits without sof -> all outputs 0, busy=0, no valid_out; following sof+64 bits captured correctly.

Source files
------------

// File: rtl/deserializer_1to64_serdes.sv
// Serial-to-parallel word assembler: MSB-first bits framed by sof, one-deep
// output holding register with ready handshake, overflow and framing pulses.
module deserializer_1to64_serdes #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_serial,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] word;
  logic             done;

  always_ff @(posedge clk_serial) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: bit capture, framing, and output handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    ferr_d  = 1'b0;
    done    = 1'b0;
    word    = {shift_q[WIDTH-2:0], serial_in};

    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end

    if (bit_valid) begin
      if (sof) begin
        // sof always (re)starts a word; mid-word it discards the partial one
        ferr_d  = (state_q == SHIFT);
        state_d = SHIFT;
        cnt_d   = CW'(1);
        shift_d = WIDTH'(serial_in);
      end else if (state_q == SHIFT) begin
        shift_d = word;
        if (cnt_q == LAST_CNT) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    if (done) begin
      if (!valid_q || ready_in) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (state_d == SHIFT);
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_deserializer_1to64_serdes.sv
// Directed and randomized bench for deserializer_1to64_serdes against a
// queue-based word-assembly model.
module tb_deserializer_1to64_serdes;

  logic        clk_serial;
  logic        rst;
  logic        serial_in;
  logic        bit_valid;
  logic        sof;
  logic [63:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic        overflow;
  logic        frame_err;

  deserializer_1to64_serdes #(.WIDTH(64)) dut (
    .clk_serial (clk_serial),
    .rst        (rst),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .busy       (busy),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk_serial = 1'b0;
  always #5 clk_serial = ~clk_serial;

  int errors = 0;
  int checks = 0;

  // Reference model: the bits of the word in progress are kept in a queue
  bit          m_in_word;
  bit          m_bits[$];
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ovf;
  logic        m_ferr;

  // Observed event counters, cleared per scenario
  int n_ferr, n_ovf, n_vhi, n_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic v,
                            input logic b, input logic rd);
    logic [63:0] w;
    bit complete;
    complete = 0;
    w = '0;
    if (r) begin
      m_in_word = 0;
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_ferr  = 1'b0;
      return;
    end
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    if (v) begin
      if (s) begin
        if (m_in_word) m_ferr = 1'b1;
        m_bits.delete();
        m_bits.push_back(b);
        m_in_word = 1;
      end else if (m_in_word) begin
        m_bits.push_back(b);
        if (m_bits.size() == 64) begin
          for (int i = 0; i < 64; i++) w[63-i] = m_bits[i];
          m_bits.delete();
          m_in_word = 0;
          complete = 1;
        end
      end
    end
    if (complete) begin
      if (!m_valid || rd) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic b, input logic rd);
    @(negedge clk_serial);
    rst = r; sof = s; bit_valid = v; serial_in = b; ready_in = rd;
    @(posedge clk_serial);
    model_step(r, s, v, b, rd);
    #1;
    chk("data_out",  data_out,          m_data);
    chk("valid_out", 64'(valid_out),    64'(m_valid));
    chk("busy",      64'(busy),         64'(m_in_word));
    chk("overflow",  64'(overflow),     64'(m_ovf));
    chk("frame_err", 64'(frame_err),    64'(m_ferr));
    if (frame_err) n_ferr++;
    if (overflow)  n_ovf++;
    if (valid_out) n_vhi++;
    if (busy)      n_busy++;
  endtask

  task automatic clr_cnt();
    n_ferr = 0; n_ovf = 0; n_vhi = 0; n_busy = 0;
  endtask

  task automatic send_word(input logic [63:0] w, input logic rd, input bit gaps);
    for (int i = 0; i < 64; i++) begin
      if (gaps && i > 0) cyc(1'b0, 1'($urandom), 1'b0, 1'($urandom), rd);
      cyc(1'b0, (i == 0), 1'b1, w[63-i], rd);
    end
  endtask

  logic [63:0] w1, w2;

  initial begin
    rst = 1'b1; sof = 1'b0; bit_valid = 1'b0; serial_in = 1'b0; ready_in = 1'b0;
    m_in_word = 0; m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    clr_cnt();

    // Reset, then one word with the consumer always ready
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_data", data_out, 64'h0);
    chk("reset_valid", 64'(valid_out), 64'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b1);
    clr_cnt();
    send_word(64'hAAAABBBB_12345678, 1'b1, 0);
    chk("w0_data", data_out, 64'hAAAABBBB_12345678);
    chk("w0_busy_cycles", 64'(n_busy), 64'd63);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w0_valid_cycles", 64'(n_vhi), 64'd1);

    // Back-to-back words
    clr_cnt();
    send_word(64'hAAAABBBB_00000001, 1'b1, 0);
    chk("b2b_first", data_out, 64'hAAAABBBB_00000001);
    send_word(64'hAAAABBBB_FFFFFFFE, 1'b1, 0);
    chk("b2b_second", data_out, 64'hAAAABBBB_FFFFFFFE);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid_cycles", 64'(n_vhi), 64'd2);
    chk("b2b_no_ferr", 64'(n_ferr), 64'd0);
    chk("b2b_no_ovf", 64'(n_ovf), 64'd0);

    // bit_valid every other cycle
    send_word(64'h0123456789ABCDEF, 1'b1, 1);
    chk("gap_data", data_out, 64'h0123456789ABCDEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // sof mid-word at bit 20
    clr_cnt();
    w1 = {$urandom, $urandom};
    for (int i = 0; i < 19; i++) cyc(1'b0, (i == 0), 1'b1, w1[63-i], 1'b1);
    send_word(64'hDEADBEEF_CAFEF00D, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ferr_count", 64'(n_ferr), 64'd1);
    chk("ferr_valid_cycles", 64'(n_vhi), 64'd1);
    chk("ferr_data", data_out, 64'hDEADBEEF_CAFEF00D);

    // Overflow: consumer stalled across two completions
    clr_cnt();
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    send_word(w1, 1'b0, 0);
    send_word(w2, 1'b0, 0);
    chk("ovf_count", 64'(n_ovf), 64'd1);
    chk("ovf_held", data_out, w1);
    chk("ovf_valid_held", 64'(valid_out), 64'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drain", 64'(valid_out), 64'h0);

    // Reset mid-word, then bits without sof are ignored
    w1 = {$urandom, $urandom};
    for (int i = 0; i < 29; i++) cyc(1'b0, (i == 0), 1'b1, w1[63-i], 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    clr_cnt();
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
    chk("rst_busy_cycles", 64'(n_busy + n_vhi + n_ovf + n_ferr), 64'd0);
    chk("rst_data", data_out, 64'h0);
    w2 = {$urandom, $urandom};
    send_word(w2, 1'b1, 0);
    chk("rst_recover", data_out, w2);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 79) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
